// File: rtl/sd_pkg.sv
// Shared definitions for the SDRAM port arbiter: widths, command encodings,
// client id type and arbiter state enum.
package sd_pkg;

    localparam int ADDRESS_SIZE = 20;
    localparam int DATA_SIZE    = 16;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } sd_cmd_e;

    typedef logic client_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Read wins over write, the same order the controller applies.
    function automatic sd_cmd_e pick_cmd(input logic rd, input logic wr);
        if (rd) return CMD_READ;
        if (wr) return CMD_WRITE;
        return CMD_NOP;
    endfunction

endpackage

// File: rtl/sd_tag_fifo.sv
// 1-bit tag FIFO holding the client id of each granted read still awaiting data.
module sd_tag_fifo
    import sd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       i_Rst_n,
    input  logic       push_i,
    input  client_id_t push_id_i,
    input  logic       pop_i,
    output client_id_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage needs no reset; entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_id_i;
    end

endmodule

// File: rtl/sd_port_arbiter.sv
// Two-client front end sharing the SDRAM controller port; tags reads so data
// returns to the issuing client. Define SD_ARB_ROUND_ROBIN_EN for fairness + cap.
module sd_port_arbiter
    import sd_pkg::*;
#(
    parameter int ADDRESS_SIZE = sd_pkg::ADDRESS_SIZE,
    parameter int DATA_SIZE    = sd_pkg::DATA_SIZE,
    parameter int TAG_DEPTH    = 8,
    parameter int MAX_GRANTS   = 16
) (
    input  logic                    clk,
    input  logic                    i_Rst_n,
    input  logic                    i_C0_Read_Request,
    input  logic                    i_C0_Write_Request,
    input  logic [ADDRESS_SIZE-1:0] i_C0_Address,
    input  logic [DATA_SIZE-1:0]    i_C0_Write_Data,
    output logic                    o_C0_Read_Grant,
    output logic                    o_C0_Write_Grant,
    output logic [DATA_SIZE-1:0]    o_C0_Read_Data,
    output logic                    o_C0_Data_Valid,
    input  logic                    i_C1_Read_Request,
    input  logic                    i_C1_Write_Request,
    input  logic [ADDRESS_SIZE-1:0] i_C1_Address,
    input  logic [DATA_SIZE-1:0]    i_C1_Write_Data,
    output logic                    o_C1_Read_Grant,
    output logic                    o_C1_Write_Grant,
    output logic [DATA_SIZE-1:0]    o_C1_Read_Data,
    output logic                    o_C1_Data_Valid,
    output logic                    o_Read_Request,
    output logic                    o_Write_Request,
    output logic [ADDRESS_SIZE-1:0] o_Read_Address,
    output logic [ADDRESS_SIZE-1:0] o_Write_Address,
    output logic [DATA_SIZE-1:0]    o_Write_Data,
    input  logic                    i_Read_Grant,
    input  logic                    i_Write_Grant,
    input  logic                    i_Data_Valid,
    input  logic [DATA_SIZE-1:0]    i_Read_Data,
    output logic                    o_Tag_Underflow
);

    localparam int CNT_W = $clog2(MAX_GRANTS + 1);

    arb_state_e       state_q, state_d;
    client_id_t       owner_q, owner_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    client_id_t sel, cur;
    logic       c0_req, c1_req, owner_req, other_req;
    logic       cap_hit, fwd_active, release_now;
    logic       rd_gnt, wr_gnt, any_gnt;
    logic       fifo_full, fifo_empty, fifo_pop;
    client_id_t fifo_head;
    sd_cmd_e    cmd;

    logic                 c0_valid_q, c1_valid_q, underflow_q;
    logic [DATA_SIZE-1:0] c0_data_q, c1_data_q;

    assign c0_req    = i_C0_Read_Request | i_C0_Write_Request;
    assign c1_req    = i_C1_Read_Request | i_C1_Write_Request;
    assign owner_req = owner_q ? c1_req : c0_req;
    assign other_req = owner_q ? c0_req : c1_req;

`ifdef SD_ARB_ROUND_ROBIN_EN
    client_id_t last_owner_q;

    assign sel     = (c0_req && c1_req) ? ~last_owner_q : c1_req;
    assign cap_hit = (state_q == OWN) && (grant_cnt_q >= CNT_W'(MAX_GRANTS)) && other_req;

    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n)         last_owner_q <= 1'b1;
        else if (release_now) last_owner_q <= owner_q;
    end
`else
    assign sel     = ~c0_req & c1_req;
    assign cap_hit = 1'b0;
`endif

    // In IDLE the freshly selected client is forwarded in the same cycle.
    assign cur         = (state_q == IDLE) ? sel : owner_q;
    assign fwd_active  = (state_q == IDLE) ? (c0_req | c1_req) : ~cap_hit;
    assign release_now = (state_q == OWN) && (!owner_req || cap_hit);

    always_comb begin
        cmd = CMD_NOP;
        if (fwd_active) begin
            if (cur) cmd = pick_cmd(i_C1_Read_Request & ~fifo_full, i_C1_Write_Request);
            else     cmd = pick_cmd(i_C0_Read_Request & ~fifo_full, i_C0_Write_Request);
        end
    end

    assign o_Read_Request  = (cmd == CMD_READ);
    assign o_Write_Request = (cmd == CMD_WRITE);
    assign o_Read_Address  = cur ? i_C1_Address : i_C0_Address;
    assign o_Write_Address = o_Read_Address;
    assign o_Write_Data    = cur ? i_C1_Write_Data : i_C0_Write_Data;

    assign rd_gnt  = i_Read_Grant & fwd_active;
    assign wr_gnt  = i_Write_Grant & fwd_active;
    assign any_gnt = rd_gnt | wr_gnt;

    assign o_C0_Read_Grant  = rd_gnt & ~cur;
    assign o_C0_Write_Grant = wr_gnt & ~cur;
    assign o_C1_Read_Grant  = rd_gnt & cur;
    assign o_C1_Write_Grant = wr_gnt & cur;

    // The IDLE-cycle grant belongs to the new ownership period, so it seeds the count.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        grant_cnt_d = grant_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (c0_req | c1_req) begin
                    state_d     = OWN;
                    owner_d     = sel;
                    grant_cnt_d = any_gnt ? CNT_W'(1) : '0;
                end
            end
            OWN: begin
                if (release_now) begin
                    state_d = IDLE;
                end else if (any_gnt && grant_cnt_q < CNT_W'(MAX_GRANTS)) begin
                    grant_cnt_d = grant_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign fifo_pop = i_Data_Valid & ~fifo_empty;

    sd_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .i_Rst_n   (i_Rst_n),
        .push_i    (rd_gnt),
        .push_id_i (cur),
        .pop_i     (i_Data_Valid),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            c0_valid_q  <= 1'b0;
            c1_valid_q  <= 1'b0;
            c0_data_q   <= '0;
            c1_data_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            c0_valid_q  <= fifo_pop & ~fifo_head;
            c1_valid_q  <= fifo_pop & fifo_head;
            if (fifo_pop && !fifo_head) c0_data_q <= i_Read_Data;
            if (fifo_pop && fifo_head)  c1_data_q <= i_Read_Data;
            underflow_q <= underflow_q | (i_Data_Valid & fifo_empty);
        end
    end

    assign o_C0_Data_Valid = c0_valid_q;
    assign o_C1_Data_Valid = c1_valid_q;
    assign o_C0_Read_Data  = c0_data_q;
    assign o_C1_Read_Data  = c1_data_q;
    assign o_Tag_Underflow = underflow_q;

endmodule

// File: tb/tb_sd_port_arbiter.sv
// Directed bench for sd_port_arbiter: ownership, grant routing, read tagging,
// tag-FIFO full mask, fairness cap (when SD_ARB_ROUND_ROBIN_EN) and underflow.
module tb_sd_port_arbiter;

    logic        clk = 1'b0;
    logic        i_Rst_n;
    logic        i_C0_Read_Request, i_C0_Write_Request;
    logic [19:0] i_C0_Address;
    logic [15:0] i_C0_Write_Data;
    logic        o_C0_Read_Grant, o_C0_Write_Grant;
    logic [15:0] o_C0_Read_Data;
    logic        o_C0_Data_Valid;
    logic        i_C1_Read_Request, i_C1_Write_Request;
    logic [19:0] i_C1_Address;
    logic [15:0] i_C1_Write_Data;
    logic        o_C1_Read_Grant, o_C1_Write_Grant;
    logic [15:0] o_C1_Read_Data;
    logic        o_C1_Data_Valid;
    logic        o_Read_Request, o_Write_Request;
    logic [19:0] o_Read_Address, o_Write_Address;
    logic [15:0] o_Write_Data;
    logic        i_Read_Grant, i_Write_Grant, i_Data_Valid;
    logic [15:0] i_Read_Data;
    logic        o_Tag_Underflow;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sd_port_arbiter dut (
        .clk                (clk),
        .i_Rst_n            (i_Rst_n),
        .i_C0_Read_Request  (i_C0_Read_Request),
        .i_C0_Write_Request (i_C0_Write_Request),
        .i_C0_Address       (i_C0_Address),
        .i_C0_Write_Data    (i_C0_Write_Data),
        .o_C0_Read_Grant    (o_C0_Read_Grant),
        .o_C0_Write_Grant   (o_C0_Write_Grant),
        .o_C0_Read_Data     (o_C0_Read_Data),
        .o_C0_Data_Valid    (o_C0_Data_Valid),
        .i_C1_Read_Request  (i_C1_Read_Request),
        .i_C1_Write_Request (i_C1_Write_Request),
        .i_C1_Address       (i_C1_Address),
        .i_C1_Write_Data    (i_C1_Write_Data),
        .o_C1_Read_Grant    (o_C1_Read_Grant),
        .o_C1_Write_Grant   (o_C1_Write_Grant),
        .o_C1_Read_Data     (o_C1_Read_Data),
        .o_C1_Data_Valid    (o_C1_Data_Valid),
        .o_Read_Request     (o_Read_Request),
        .o_Write_Request    (o_Write_Request),
        .o_Read_Address     (o_Read_Address),
        .o_Write_Address    (o_Write_Address),
        .o_Write_Data       (o_Write_Data),
        .i_Read_Grant       (i_Read_Grant),
        .i_Write_Grant      (i_Write_Grant),
        .i_Data_Valid       (i_Data_Valid),
        .i_Read_Data        (i_Read_Data),
        .o_Tag_Underflow    (o_Tag_Underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic exp_c0, exp_c1, exp_req;

        i_Rst_n = 1'b0;
        {i_C0_Read_Request, i_C0_Write_Request, i_C1_Read_Request, i_C1_Write_Request} = '0;
        i_C0_Address = '0; i_C1_Address = '0;
        i_C0_Write_Data = '0; i_C1_Write_Data = '0;
        i_Read_Grant = 1'b0; i_Write_Grant = 1'b0;
        i_Data_Valid = 1'b0; i_Read_Data = '0;
        #2;
        check("rst_read_req",  o_Read_Request,  0);
        check("rst_write_req", o_Write_Request, 0);
        check("rst_c0_valid",  o_C0_Data_Valid, 0);
        check("rst_c1_data",   o_C1_Read_Data,  0);
        check("rst_underflow", o_Tag_Underflow, 0);
        tick();
        i_Rst_n = 1'b1;

        // Both clients read in the same cycle: client 0 wins first.
        tick();
        i_C0_Read_Request = 1'b1; i_C0_Address = 20'h00100;
        i_C1_Read_Request = 1'b1; i_C1_Address = 20'h00200;
        settle();
        check("t1_read_req",  o_Read_Request, 1);
        check("t1_read_addr", o_Read_Address, 20'h00100);
        i_Read_Grant = 1'b1;
        settle();
        check("t1_c0_grant", o_C0_Read_Grant, 1);
        check("t1_c1_grant", o_C1_Read_Grant, 0);
        tick();
        i_C0_Read_Request = 1'b0; i_Read_Grant = 1'b0;
        settle();
        check("t1_release_req", o_Read_Request, 0);
        tick();
        check("t1_c1_read_req",  o_Read_Request, 1);
        check("t1_c1_read_addr", o_Read_Address, 20'h00200);
        i_Read_Grant = 1'b1;
        settle();
        check("t1_c1_grant_b", o_C1_Read_Grant, 1);
        check("t1_c0_grant_b", o_C0_Read_Grant, 0);
        tick();
        i_C1_Read_Request = 1'b0; i_Read_Grant = 1'b0;

        // Read return in grant order: C0 tag first, then C1.
        repeat (2) tick();
        i_Data_Valid = 1'b1; i_Read_Data = 16'hA5A5;
        settle();
        check("t2_c0_valid_early", o_C0_Data_Valid, 0);
        tick();
        i_Read_Data = 16'h5A5A;
        check("t2_c0_valid", o_C0_Data_Valid, 1);
        check("t2_c0_data",  o_C0_Read_Data,  16'hA5A5);
        check("t2_c1_valid", o_C1_Data_Valid, 0);
        tick();
        i_Data_Valid = 1'b0; i_Read_Data = '0;
        check("t2_c1_valid_b", o_C1_Data_Valid, 1);
        check("t2_c1_data_b",  o_C1_Read_Data,  16'h5A5A);
        check("t2_c0_valid_b", o_C0_Data_Valid, 0);
        check("t2_c0_data_b",  o_C0_Read_Data,  16'hA5A5);
        tick();
        check("t2_c1_valid_c", o_C1_Data_Valid, 0);
        check("t2_underflow",  o_Tag_Underflow, 0);

        // Client 1 write forwarding and routing.
        i_C1_Write_Request = 1'b1; i_C1_Address = 20'h00333; i_C1_Write_Data = 16'h1234;
        settle();
        check("t3_write_req",  o_Write_Request, 1);
        check("t3_read_req",   o_Read_Request,  0);
        check("t3_write_addr", o_Write_Address, 20'h00333);
        check("t3_write_data", o_Write_Data,    16'h1234);
        i_Write_Grant = 1'b1;
        settle();
        check("t3_c1_wgrant", o_C1_Write_Grant, 1);
        check("t3_c0_wgrant", o_C0_Write_Grant, 0);
        tick();
        i_C1_Write_Request = 1'b0; i_Write_Grant = 1'b0;
        tick();

        // Read has priority over write within the owner.
        i_C0_Read_Request = 1'b1; i_C0_Write_Request = 1'b1;
        settle();
        check("t4_prio_read",  o_Read_Request,  1);
        check("t4_prio_write", o_Write_Request, 0);
        i_C0_Write_Request = 1'b0;

        // Eight reads fill the tag FIFO; the read request stays masked until data returns.
        i_Read_Grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            check($sformatf("t5_fill_req_%0d", i), o_Read_Request, 1);
            tick();
        end
        i_Read_Grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("t5_masked_%0d", i), o_Read_Request, 0);
            tick();
        end
        i_Data_Valid = 1'b1; i_Read_Data = 16'h0F0F;
        settle();
        check("t5_masked_on_pop", o_Read_Request, 0);
        tick();
        i_Data_Valid = 1'b0;
        check("t5_unmasked",   o_Read_Request,  1);
        check("t5_pop_valid",  o_C0_Data_Valid, 1);
        check("t5_pop_data",   o_C0_Read_Data,  16'h0F0F);
        i_Read_Grant = 1'b1;
        settle();
        check("t5_next_grant", o_C0_Read_Grant, 1);
        tick();
        i_Read_Grant = 1'b0; i_C0_Read_Request = 1'b0;
        tick();
        i_Data_Valid = 1'b1;
        repeat (8) tick();
        i_Data_Valid = 1'b0;
        tick();
        check("t5_drained_no_uf", o_Tag_Underflow, 0);

        // Both clients write continuously; client 1 joins one cycle after client 0.
        i_C0_Write_Request = 1'b1; i_C0_Address = 20'h00010;
        for (int i = 0; i < 20; i++) begin
`ifdef SD_ARB_ROUND_ROBIN_EN
            exp_req = (i != 16);
            exp_c0  = (i < 16);
            exp_c1  = (i >= 17);
`else
            exp_req = 1'b1;
            exp_c0  = 1'b1;
            exp_c1  = 1'b0;
`endif
            if (i == 1) i_C1_Write_Request = 1'b1;
            i_Write_Grant = exp_req;
            settle();
            check($sformatf("t6_wreq_%0d", i),   o_Write_Request,  exp_req);
            check($sformatf("t6_c0_wgnt_%0d", i), o_C0_Write_Grant, exp_c0);
            check($sformatf("t6_c1_wgnt_%0d", i), o_C1_Write_Grant, exp_c1);
            tick();
        end
        i_Write_Grant = 1'b0;
        i_C0_Write_Request = 1'b0; i_C1_Write_Request = 1'b0;
        repeat (2) tick();

        // Data with no read outstanding is dropped and flags underflow until reset.
        i_Data_Valid = 1'b1; i_Read_Data = 16'hBEEF;
        tick();
        i_Data_Valid = 1'b0;
        check("t7_c0_valid", o_C0_Data_Valid, 0);
        check("t7_c1_valid", o_C1_Data_Valid, 0);
        check("t7_underflow", o_Tag_Underflow, 1);
        repeat (3) tick();
        check("t7_sticky", o_Tag_Underflow, 1);
        i_Rst_n = 1'b0;
        settle();
        check("t7_rst_clear", o_Tag_Underflow, 0);
        check("t7_rst_c0_data", o_C0_Read_Data, 0);
        tick();
        i_Rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected $finish");
        $fatal(1, "timeout");
    end

endmodule
